// File: rtl/udp_tx_framer.sv
// UDP transmit framer: emits the 8-byte UDP header followed by FIFO payload,
// one DW-bit beat per ip_rq cycle, with underrun and abort detection.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for tx_go; header fields may be re-latched
// S_ARMED | fields latched, waiting for the first ip_rq (beat 0)
// S_HDR   | streaming header beats 1 .. HB-1
// S_PAY   | streaming payload beats HB .. HB+PB-1
// S_DONE  | one-cycle done pulse, then back to idle
module udp_tx_framer #(
    parameter int DW       = 4,
    parameter int CKSUM_EN = 1
) (
    input  logic          mii_tx_clk,
    input  logic          rst_n,
    input  logic          tx_go,
    input  logic [15:0]   data_len,
    input  logic [15:0]   sour_port,
    input  logic [15:0]   dest_port,
    input  logic [15:0]   udp_ck_sum,
    output logic [15:0]   ip_len,
    input  logic          ip_rq,
    output logic [DW-1:0] ip_data,
    output logic          fifo_rq,
    input  logic [DW-1:0] fifo_da,
    input  logic          fifo_empty,
    output logic          busy,
    output logic          done,
    output logic          underrun,
    output logic          abort
);
    localparam int          HB    = 64 / DW;
    localparam logic [16:0] HB_M1 = 17'(HB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HDR,
        S_PAY,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [16:0]   cnt_q, cnt_d;
    logic [15:0]   sport_q, sport_d;
    logic [15:0]   dport_q, dport_d;
    logic [15:0]   dlen_q, dlen_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   ck_q, ck_d;
    logic [DW-1:0] data_q, data_d;
    logic          under_q, under_d;
    logic          abort_q, abort_d;
    logic          empty_q, empty_d;

    logic [16:0]   pb;
    logic [16:0]   last_idx;
    logic [63:0]   hdr;
    logic [63:0]   hdr_ord;
    logic [DW-1:0] hdr_beat;
    logic          in_beat_state;

    // Payload beat count: two nibbles or one byte per payload byte.
    always_comb begin
        if (DW == 4) begin
            pb = {dlen_q, 1'b0};
        end else begin
            pb = {1'b0, dlen_q};
        end
        last_idx = HB_M1 + pb;
    end

    // On the nibble path each byte goes out low nibble first, so swap nibbles
    // up front and then every datapath simply walks the vector MSB-first.
    always_comb begin
        hdr     = {sport_q, dport_q, len_q, ck_q};
        hdr_ord = hdr;
        if (DW == 4) begin
            for (int b = 0; b < 8; b++) begin
                hdr_ord[8*b +: 8] = {hdr[8*b +: 4], hdr[8*b+4 +: 4]};
            end
        end
    end

    always_comb begin
        hdr_beat = '0;
        for (int k = 0; k < HB; k++) begin
            if (cnt_q[3:0] == 4'(k)) begin
                hdr_beat = hdr_ord[DW*(HB-1-k) +: DW];
            end
        end
    end

    assign in_beat_state = (state_q == S_HDR) || (state_q == S_PAY);
    assign fifo_rq       = in_beat_state && ip_rq &&
                           (cnt_q >= HB_M1) && (cnt_q < last_idx);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sport_d = sport_q;
        dport_d = dport_q;
        dlen_d  = dlen_q;
        len_d   = len_q;
        ck_d    = ck_q;
        data_d  = '0;
        under_d = under_q;
        abort_d = 1'b0;
        empty_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_go) begin
                    sport_d = sour_port;
                    dport_d = dest_port;
                    dlen_d  = data_len;
                    len_d   = data_len + 16'd8;
                    ck_d    = (CKSUM_EN != 0) ? udp_ck_sum : 16'h0000;
                    under_d = 1'b0;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (ip_rq) begin
                    data_d  = hdr_beat;
                    cnt_d   = cnt_q + 17'd1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (!ip_rq) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    data_d = hdr_beat;
                    cnt_d  = cnt_q + 17'd1;
                    if (cnt_q == HB_M1) begin
                        state_d = (pb == 17'd0) ? S_DONE : S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (!ip_rq) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    // A read issued against an empty FIFO yields a zero beat.
                    data_d = empty_q ? '0 : fifo_da;
                    cnt_d  = cnt_q + 17'd1;
                    if (cnt_q == last_idx) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (fifo_rq && fifo_empty) begin
            under_d = 1'b1;
            empty_d = 1'b1;
        end
    end

    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sport_q <= '0;
            dport_q <= '0;
            dlen_q  <= '0;
            len_q   <= '0;
            ck_q    <= '0;
            data_q  <= '0;
            under_q <= 1'b0;
            abort_q <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sport_q <= sport_d;
            dport_q <= dport_d;
            dlen_q  <= dlen_d;
            len_q   <= len_d;
            ck_q    <= ck_d;
            data_q  <= data_d;
            under_q <= under_d;
            abort_q <= abort_d;
            empty_q <= empty_d;
        end
    end

    assign ip_len   = len_q;
    assign ip_data  = data_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign underrun = under_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: instance A is MII (DW=4, checksum on),
// instance B is GMII (DW=8, checksum forced to zero).
module tb_udp_tx_framer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_go_a, tx_go_b;
    logic        ip_rq_a, ip_rq_b;
    logic [15:0] data_len, sour_port, dest_port, udp_ck_sum;
    logic [3:0]  fifo_da_a;
    logic [7:0]  fifo_da_b;
    logic        fifo_empty;

    logic [15:0] ip_len_a, ip_len_b;
    logic [3:0]  ip_data_a;
    logic [7:0]  ip_data_b;
    logic        fifo_rq_a, fifo_rq_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic        underrun_a, underrun_b, abort_a, abort_b;

    always #5 clk = ~clk;

    udp_tx_framer #(.DW(4), .CKSUM_EN(1)) u_a (
        .mii_tx_clk(clk), .rst_n(rst_n), .tx_go(tx_go_a), .data_len(data_len),
        .sour_port(sour_port), .dest_port(dest_port), .udp_ck_sum(udp_ck_sum),
        .ip_len(ip_len_a), .ip_rq(ip_rq_a), .ip_data(ip_data_a), .fifo_rq(fifo_rq_a),
        .fifo_da(fifo_da_a), .fifo_empty(fifo_empty), .busy(busy_a), .done(done_a),
        .underrun(underrun_a), .abort(abort_a)
    );

    udp_tx_framer #(.DW(8), .CKSUM_EN(0)) u_b (
        .mii_tx_clk(clk), .rst_n(rst_n), .tx_go(tx_go_b), .data_len(data_len),
        .sour_port(sour_port), .dest_port(dest_port), .udp_ck_sum(udp_ck_sum),
        .ip_len(ip_len_b), .ip_rq(ip_rq_b), .ip_data(ip_data_b), .fifo_rq(fifo_rq_b),
        .fifo_da(fifo_da_b), .fifo_empty(fifo_empty), .busy(busy_b), .done(done_b),
        .underrun(underrun_b), .abort(abort_b)
    );

    int nerr = 0;
    int nchk = 0;

    logic [7:0]  pay    [64];
    logic [7:0]  l_data [64];
    logic [15:0] l_len  [64];
    logic        l_rq   [64];
    logic        l_done [64];
    logic        l_busy [64];
    logic        l_abort[64];
    logic        l_under[64];

    // Starts a frame on instance A (sel=0) or B (sel=1) and logs ncyc cycles.
    // Log cycle 0 is the first cycle after tx_go is accepted.
    task automatic run_frame(input bit sel, input logic [15:0] len, input logic [15:0] sp,
                             input logic [15:0] dp, input logic [15:0] ck, input int ncyc,
                             input int drop_at, input int empty_rd, input int go_again_at,
                             input bit rq_early);
        int rd;
        bit prev_rq;
        bit cur_rq;
        @(posedge clk); #1;
        data_len = len; sour_port = sp; dest_port = dp; udp_ck_sum = ck;
        ip_rq_a = 1'b0; ip_rq_b = 1'b0; fifo_empty = 1'b0;
        if (sel) tx_go_b = 1'b1; else tx_go_a = 1'b1;
        if (rq_early) begin
            if (sel) ip_rq_b = 1'b1; else ip_rq_a = 1'b1;
        end
        @(posedge clk); #1;
        tx_go_a = 1'b0; tx_go_b = 1'b0;
        rd = 0;
        prev_rq = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (sel) ip_rq_b = (c < drop_at); else ip_rq_a = (c < drop_at);
            fifo_da_a = 4'h0;
            fifo_da_b = 8'h00;
            if (prev_rq) begin
                fifo_da_a = pay[rd-1][3:0];
                fifo_da_b = pay[rd-1];
            end
            fifo_empty = (rd == empty_rd);
            if (c == go_again_at) begin
                sour_port = 16'hDEAD; dest_port = 16'hBEEF; data_len = 16'h0100;
                if (sel) tx_go_b = 1'b1; else tx_go_a = 1'b1;
            end else begin
                tx_go_a = 1'b0; tx_go_b = 1'b0;
            end
            #1;
            cur_rq     = sel ? fifo_rq_b : fifo_rq_a;
            l_data[c]  = sel ? ip_data_b : {4'h0, ip_data_a};
            l_len[c]   = sel ? ip_len_b : ip_len_a;
            l_rq[c]    = cur_rq;
            l_done[c]  = sel ? done_b : done_a;
            l_busy[c]  = sel ? busy_b : busy_a;
            l_abort[c] = sel ? abort_b : abort_a;
            l_under[c] = sel ? underrun_b : underrun_a;
            if (cur_rq) rd++;
            prev_rq = cur_rq;
            @(posedge clk); #1;
        end
        tx_go_a = 1'b0; tx_go_b = 1'b0; fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        nchk++; if (ip_data_a !== 4'h0) begin nerr++; $display("FAIL reset ip_data: got %h want 0", ip_data_a); end
        nchk++; if (ip_len_a !== 16'h0) begin nerr++; $display("FAIL reset ip_len: got %h want 0", ip_len_a); end
        nchk++; if (fifo_rq_a !== 1'b0) begin nerr++; $display("FAIL reset fifo_rq: got %b want 0", fifo_rq_a); end
        nchk++; if (busy_a !== 1'b0) begin nerr++; $display("FAIL reset busy: got %b want 0", busy_a); end
        nchk++; if (done_a !== 1'b0) begin nerr++; $display("FAIL reset done: got %b want 0", done_a); end
        nchk++; if (underrun_a !== 1'b0) begin nerr++; $display("FAIL reset underrun: got %b want 0", underrun_a); end
        nchk++; if (abort_a !== 1'b0) begin nerr++; $display("FAIL reset abort: got %b want 0", abort_a); end
        nchk++; if ({ip_data_b, ip_len_b, busy_b} !== 25'h0) begin nerr++; $display("FAIL reset B outputs: got %h want 0", {ip_data_b, ip_len_b, busy_b}); end
    endtask

    task automatic test_header_dw4();
        logic [7:0] hx [16];
        int n;
        hx = '{8'h2, 8'h1, 8'h4, 8'h3, 8'h6, 8'h5, 8'h8, 8'h7,
               8'h0, 8'h0, 8'hB, 8'h0, 8'hB, 8'hA, 8'hD, 8'hC};
        pay[0] = 8'h9; pay[1] = 8'hA; pay[2] = 8'h5; pay[3] = 8'hC; pay[4] = 8'h3; pay[5] = 8'hE;
        run_frame(1'b0, 16'd3, 16'h1234, 16'h5678, 16'hABCD, 26, 1000, -1, -1, 1'b0);
        nchk++; if (l_len[0] !== 16'h000B) begin nerr++; $display("FAIL hdr4 ip_len: got %h want 000b", l_len[0]); end
        nchk++; if (l_data[0] !== 8'h0) begin nerr++; $display("FAIL hdr4 latency: got %h want 0", l_data[0]); end
        for (int i = 0; i < 16; i++) begin
            nchk++; if (l_data[i+1] !== hx[i]) begin nerr++; $display("FAIL hdr4 beat %0d: got %h want %h", i, l_data[i+1], hx[i]); end
        end
        for (int j = 0; j < 6; j++) begin
            nchk++; if (l_data[17+j] !== {4'h0, pay[j][3:0]}) begin nerr++; $display("FAIL hdr4 payload %0d: got %h want %h", j, l_data[17+j], pay[j][3:0]); end
        end
        n = 0;
        for (int c = 0; c < 26; c++) n += int'(l_done[c]);
        nchk++; if (n != 1 || l_done[22] !== 1'b1) begin nerr++; $display("FAIL hdr4 done: got count %0d at22=%b want 1/1", n, l_done[22]); end
        nchk++; if (l_busy[22] !== 1'b1 || l_busy[23] !== 1'b0) begin nerr++; $display("FAIL hdr4 busy fall: got %b%b want 10", l_busy[22], l_busy[23]); end
        for (int c = 23; c < 26; c++) begin
            nchk++; if (l_data[c] !== 8'h0) begin nerr++; $display("FAIL hdr4 idle data cyc %0d: got %h want 0", c, l_data[c]); end
        end
        n = 0;
        for (int c = 0; c < 26; c++) n += int'(l_rq[c]);
        nchk++; if (n != 6 || l_rq[15] !== 1'b1 || l_rq[14] !== 1'b0) begin nerr++; $display("FAIL hdr4 fifo_rq: got count %0d first=%b want 6/1", n, l_rq[15]); end
    endtask

    task automatic test_payload_dw8();
        logic [7:0] bx [12];
        int n;
        bx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0C, 8'h00, 8'h00,
               8'hA0, 8'hA1, 8'hA2, 8'hA3};
        pay[0] = 8'hA0; pay[1] = 8'hA1; pay[2] = 8'hA2; pay[3] = 8'hA3;
        run_frame(1'b1, 16'd4, 16'h1234, 16'h5678, 16'h9999, 15, 1000, -1, -1, 1'b0);
        nchk++; if (l_len[0] !== 16'h000C) begin nerr++; $display("FAIL pay8 ip_len: got %h want 000c", l_len[0]); end
        for (int i = 0; i < 12; i++) begin
            nchk++; if (l_data[i+1] !== bx[i]) begin nerr++; $display("FAIL pay8 beat %0d: got %h want %h", i, l_data[i+1], bx[i]); end
        end
        n = 0;
        for (int c = 0; c < 15; c++) n += int'(l_rq[c]);
        nchk++; if (n != 4 || l_rq[7] !== 1'b1 || l_rq[6] !== 1'b0) begin nerr++; $display("FAIL pay8 fifo_rq: got count %0d first=%b want 4/1", n, l_rq[7]); end
        nchk++; if (l_done[12] !== 1'b1 || l_busy[13] !== 1'b0) begin nerr++; $display("FAIL pay8 done: got %b busy %b want 1/0", l_done[12], l_busy[13]); end
    endtask

    task automatic test_zero_len();
        logic [7:0] hz [16];
        int n;
        hz = '{8'h2, 8'h1, 8'h4, 8'h3, 8'h6, 8'h5, 8'h8, 8'h7,
               8'h0, 8'h0, 8'h8, 8'h0, 8'hB, 8'hA, 8'hD, 8'hC};
        run_frame(1'b0, 16'd0, 16'h1234, 16'h5678, 16'hABCD, 19, 1000, -1, -1, 1'b0);
        nchk++; if (l_len[0] !== 16'h0008) begin nerr++; $display("FAIL zero ip_len: got %h want 0008", l_len[0]); end
        for (int i = 0; i < 16; i++) begin
            nchk++; if (l_data[i+1] !== hz[i]) begin nerr++; $display("FAIL zero beat %0d: got %h want %h", i, l_data[i+1], hz[i]); end
        end
        n = 0;
        for (int c = 0; c < 19; c++) n += int'(l_rq[c]);
        nchk++; if (n != 0) begin nerr++; $display("FAIL zero fifo_rq: got count %0d want 0", n); end
        nchk++; if (l_done[16] !== 1'b1 || l_done[15] !== 1'b0 || l_busy[17] !== 1'b0) begin nerr++; $display("FAIL zero done: got %b%b busy %b want 10/0", l_done[15], l_done[16], l_busy[17]); end
    endtask

    task automatic test_underrun();
        for (int k = 0; k < 6; k++) pay[k] = 8'(k + 1);
        run_frame(1'b0, 16'd3, 16'h1234, 16'h5678, 16'hABCD, 26, 1000, 2, -1, 1'b0);
        nchk++; if (l_data[17] !== 8'h1 || l_data[18] !== 8'h2) begin nerr++; $display("FAIL under good beats: got %h %h want 1 2", l_data[17], l_data[18]); end
        nchk++; if (l_data[19] !== 8'h0) begin nerr++; $display("FAIL under zero beat: got %h want 0", l_data[19]); end
        nchk++; if (l_data[20] !== 8'h4) begin nerr++; $display("FAIL under next beat: got %h want 4", l_data[20]); end
        nchk++; if (l_under[17] !== 1'b0 || l_under[18] !== 1'b1) begin nerr++; $display("FAIL under set: got %b%b want 01", l_under[17], l_under[18]); end
        nchk++; if (l_under[25] !== 1'b1) begin nerr++; $display("FAIL under sticky: got %b want 1", l_under[25]); end
        nchk++; if (l_done[22] !== 1'b1) begin nerr++; $display("FAIL under done: got %b want 1", l_done[22]); end
        // Next frame clears the flag; ip_rq also high in the tx_go cycle.
        run_frame(1'b0, 16'd3, 16'h1234, 16'h5678, 16'hABCD, 26, 1000, -1, -1, 1'b1);
        nchk++; if (l_under[0] !== 1'b0) begin nerr++; $display("FAIL under clear: got %b want 0", l_under[0]); end
        nchk++; if (l_data[0] !== 8'h0 || l_data[1] !== 8'h2) begin nerr++; $display("FAIL early rq first beat: got %h %h want 0 2", l_data[0], l_data[1]); end
        nchk++; if (l_done[22] !== 1'b1 || l_data[19] !== 8'h3) begin nerr++; $display("FAIL early rq frame: got done %b beat %h want 1 3", l_done[22], l_data[19]); end
    endtask

    task automatic test_abort();
        int n;
        for (int k = 0; k < 20; k++) pay[k] = 8'(k + 3);
        run_frame(1'b0, 16'd10, 16'h1234, 16'h5678, 16'hABCD, 24, 18, -1, -1, 1'b0);
        nchk++; if (l_abort[18] !== 1'b0 || l_abort[19] !== 1'b1 || l_abort[20] !== 1'b0) begin nerr++; $display("FAIL abort pulse: got %b%b%b want 010", l_abort[18], l_abort[19], l_abort[20]); end
        nchk++; if (l_busy[18] !== 1'b1 || l_busy[19] !== 1'b0) begin nerr++; $display("FAIL abort busy: got %b%b want 10", l_busy[18], l_busy[19]); end
        n = 0;
        for (int c = 0; c < 24; c++) n += int'(l_rq[c]);
        nchk++; if (n != 3 || l_rq[18] !== 1'b0) begin nerr++; $display("FAIL abort fifo_rq: got count %0d want 3", n); end
        n = 0;
        for (int c = 0; c < 24; c++) n += int'(l_done[c]);
        nchk++; if (n != 0) begin nerr++; $display("FAIL abort done: got count %0d want 0", n); end
        run_frame(1'b0, 16'd3, 16'h1234, 16'h5678, 16'hABCD, 26, 1000, -1, -1, 1'b0);
        nchk++; if (l_data[1] !== 8'h2 || l_data[16] !== 8'hC) begin nerr++; $display("FAIL abort restart hdr: got %h %h want 2 c", l_data[1], l_data[16]); end
        nchk++; if (l_done[22] !== 1'b1 || l_data[17] !== 8'h3) begin nerr++; $display("FAIL abort restart frame: got done %b beat %h want 1 3", l_done[22], l_data[17]); end
    endtask

    task automatic test_busy_go();
        logic [7:0] hx [16];
        hx = '{8'h2, 8'h1, 8'h4, 8'h3, 8'h6, 8'h5, 8'h8, 8'h7,
               8'h0, 8'h0, 8'hB, 8'h0, 8'hB, 8'hA, 8'hD, 8'hC};
        for (int k = 0; k < 6; k++) pay[k] = 8'(k + 8);
        run_frame(1'b0, 16'd3, 16'h1234, 16'h5678, 16'hABCD, 26, 1000, -1, 18, 1'b0);
        for (int i = 0; i < 16; i++) begin
            nchk++; if (l_data[i+1] !== hx[i]) begin nerr++; $display("FAIL busygo beat %0d: got %h want %h", i, l_data[i+1], hx[i]); end
        end
        for (int j = 0; j < 6; j++) begin
            nchk++; if (l_data[17+j] !== {4'h0, pay[j][3:0]}) begin nerr++; $display("FAIL busygo payload %0d: got %h want %h", j, l_data[17+j], pay[j][3:0]); end
        end
        nchk++; if (l_len[25] !== 16'h000B) begin nerr++; $display("FAIL busygo ip_len: got %h want 000b", l_len[25]); end
        nchk++; if (l_done[22] !== 1'b1 || l_busy[23] !== 1'b0 || l_busy[25] !== 1'b0) begin nerr++; $display("FAIL busygo end: got done %b busy %b%b want 1 00", l_done[22], l_busy[23], l_busy[25]); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 20; k++) pay[k] = 8'(k + 1);
        run_frame(1'b0, 16'd10, 16'h1234, 16'h5678, 16'hABCD, 20, 1000, -1, -1, 1'b0);
        nchk++; if (busy_a !== 1'b1 || fifo_rq_a !== 1'b1 || ip_len_a !== 16'h0012) begin nerr++; $display("FAIL rstmid pre: got busy %b rq %b len %h want 1 1 0012", busy_a, fifo_rq_a, ip_len_a); end
        rst_n = 1'b0;
        #1;
        nchk++; if (ip_data_a !== 4'h0 || ip_len_a !== 16'h0) begin nerr++; $display("FAIL rstmid data/len: got %h %h want 0 0", ip_data_a, ip_len_a); end
        nchk++; if (fifo_rq_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin nerr++; $display("FAIL rstmid ctrl: got rq %b busy %b done %b want 000", fifo_rq_a, busy_a, done_a); end
        nchk++; if (underrun_a !== 1'b0 || abort_a !== 1'b0) begin nerr++; $display("FAIL rstmid flags: got %b%b want 00", underrun_a, abort_a); end
        @(posedge clk); #1;
        ip_rq_a = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        nchk++; if (busy_a !== 1'b0 || ip_data_a !== 4'h0) begin nerr++; $display("FAIL rstmid after: got busy %b data %h want 0 0", busy_a, ip_data_a); end
    endtask

    initial begin
        rst_n = 1'b0;
        tx_go_a = 1'b0; tx_go_b = 1'b0; ip_rq_a = 1'b0; ip_rq_b = 1'b0;
        data_len = '0; sour_port = '0; dest_port = '0; udp_ck_sum = '0;
        fifo_da_a = '0; fifo_da_b = '0; fifo_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_header_dw4();
        test_payload_dw8();
        test_zero_len();
        test_underrun();
        test_abort();
        test_busy_go();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/udp_tx_framer.md
# udp_tx_framer

Parametrised UDP transmit framer between the payload FIFO and the IP transmit layer. On each beat requested by the IP layer, it supplies the 8-byte UDP header and then the payload, DW bits per beat. Header fields are latched at `tx_go`. Checksum insertion is selectable, and the block detects FIFO underrun and IP-side aborts. It covers both MII (nibble) and GMII (byte) datapaths.

## Interface

Parameters:
- `DW`, default 4: beat width; legal values are 4 (MII) and 8 (GMII).
- `CKSUM_EN`, default 1: 1 inserts the latched `udp_ck_sum`; 0 forces the checksum field to 0x0000.

Ports:
- `mii_tx_clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_go`  in  1  one-cycle start pulse; latches the header fields. Ignored unless the block is in IDLE.
- `data_len`  in  16  payload length in bytes.
- `sour_port`  in  16  UDP source port.
- `dest_port`  in  16  UDP destination port.
- `udp_ck_sum`  in  16  precomputed UDP checksum.
- `ip_len`  out  16  latched `data_len + 8`, given to the IP layer as its data length.
- `ip_rq`  in  1  beat request from the IP layer; held high for consecutive cycles.
- `ip_data`  out  DW  registered UDP beat.
- `fifo_rq`  out  DW-independent 1  payload FIFO read request; the FIFO has a 1-cycle read latency.
- `fifo_da`  in  DW  FIFO read data.
- `fifo_empty`  in  1  FIFO empty flag.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last payload beat.
- `underrun`  out  1  sticky; cleared by the next accepted `tx_go`.
- `abort`  out  1  one-cycle pulse when `ip_rq` drops mid-frame.

## Operation

- **Beat counts.**
  - Header beats: HB = 64/DW, i.e. 16 for DW=4 and 8 for DW=8.
  - Payload beats: PB = data_len·8/DW.
  - Beat counter is 17 bits wide (max PB = 131070).
- **`ip_len`.** Computed as `data_len + 8` modulo 2^16. There is no range check; the caller keeps `data_len` ≤ 65507.
- **Header order.**
  - Fields go out in this order: `sour_port`, `dest_port`, length (`data_len + 8`), checksum.
  - Each field is sent big-endian by byte.
  - For DW=4, the low nibble of each byte is sent first. Example: `sour_port` goes out as [11:8], [15:12], [3:0], [7:4].
  - For DW=8, the byte order is [15:8], then [7:0].
- **Payload.** `fifo_da` is passed through unmodified.
- **State machine.**
  - IDLE: on `tx_go`, latch all fields, clear `underrun`, go to ARMED.
  - ARMED: on `ip_rq`=1, go to HDR. The current cycle is beat 0.
  - HDR: count beats up to HB−1. Then go to PAY, or to DONE if PB=0.
  - PAY: count beats up to HB+PB−1, then go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- **Abort.** If `ip_rq`=0 in HDR or PAY:
  - pulse `abort` and go to IDLE;
  - no further `fifo_rq`; the FIFO is not flushed.
- **FIFO reads.** `fifo_rq` is asserted in every beat cycle with index i in [HB−1, HB+PB−2], with `ip_rq` high. `fifo_da` is captured in the following cycle.
- **Underrun.** If `fifo_empty`=1 in a cycle where `fifo_rq` is asserted:
  - set `underrun`;
  - the corresponding payload beat is emitted as 0;
  - the frame continues to completion.
- **Idle output.** `ip_data` is 0 outside beats, including when `ip_rq` stays high after DONE.
- **`tx_go` while busy.** Ignored, and the latched fields are unchanged.
- **`tx_go` and `ip_rq` in the same IDLE cycle.** The fields are latched; the first beat is counted on the next cycle.

## Timing

- **Reset values.** `ip_data`=0, `ip_len`=0, `fifo_rq`=0, `busy`=0, `done`=0, `underrun`=0, `abort`=0. State is IDLE and the beat counter is 0.
- **Reset mid-frame.** Takes effect immediately, with the same values as above.
- **Beat latency.** Beat i is counted in cycle t where `ip_rq`=1, and appears on `ip_data` at t+1.
- **Beat throughput.** One beat per `ip_rq` cycle, with no bubbles.
- **`fifo_rq` timing.** Combinational from the state and counter. It is asserted in the cycle before each payload beat is registered.
- **`ip_len` timing.** Valid from the cycle after `tx_go` until the next accepted `tx_go`.
- **`done` timing.** Asserted in the cycle after the last beat is registered. `busy` falls in the following cycle.

## Test plan

- **Header, DW=4, CKSUM_EN=1.**
  - Stimulus: `sour_port`=0x1234, `dest_port`=0x5678, `data_len`=3, `udp_ck_sum`=0xABCD.
  - Required: first 16 `ip_data` beats are 2,1,4,3, 6,5,8,7, 0,0,B,0, B,A,D,C.
  - Required: `ip_len`=0x000B, followed by 6 payload nibbles, then `done`.
- **Payload, DW=8, CKSUM_EN=0.**
  - Stimulus: `data_len`=4, FIFO holding bytes 0xA0–0xA3.
  - Required: beats 12,34,56,78,00,0C,00,00,A0,A1,A2,A3.
  - Required: `fifo_rq` high for exactly 4 cycles, starting on beat index 7.
- **Zero-length payload.**
  - Stimulus: `data_len`=0.
  - Required: 16 header beats (DW=4), `fifo_rq` never asserted, `done` after the header, `ip_len`=8.
- **Underrun.**
  - Stimulus: `fifo_empty`=1 during the 3rd payload read.
  - Required: that beat is 0, `underrun` goes high and stays high, `done` still pulses.
  - Required: the next `tx_go` clears `underrun`.
- **Abort.**
  - Stimulus: drop `ip_rq` at beat 18 (DW=4, `data_len`=10).
  - Required: `abort` pulses, `busy` falls, no further `fifo_rq`.
  - Required: a new `tx_go` runs a full frame.
- **Busy and reset.**
  - Stimulus: `tx_go` during PAY with new port values.
  - Required: the frame is unchanged.
  - Stimulus: `rst_n` pulse mid-PAY.
  - Required: all outputs are at their reset values in the same cycle.
